dff_mem_arbiter: RTL and testbench

- Two-port round-robin arbiter/sequencer in front of the 16x8 DFF scratch RAM.
- Accepts read/write commands from requesters A and B over valid/ready, serialises them onto the RAM's single strobe interface (rin / rout_n), and returns a one-cycle completion pulse per requester with registered read data.
- Sits between the user logic (ui_in/uio_in decode) and the RAM instance inside the tile.

---
 rtl/dff_mem_arb_pkg.sv | 30 +++
 rtl/dff_mem_arbiter_rr_arb2.sv | 49 ++++
 rtl/dff_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dff_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_mem_arb_pkg
//  Purpose  : Shared types and constants for the DFF scratch-RAM arbiter.
//             Sequencer state encoding, requester ids, default widths.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dff_mem_arb_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 8;

   // Sequencer states: IDLE accepts, ACCESS strobes the RAM, RDWAIT waits for
   // the RAM's registered read data, DONE pulses the completion.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage : dff_mem_arb_pkg
`default_nettype wire

// File: rtl/dff_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-request round-robin picker. A lone request always wins; on
//             a tie the requester that was not granted last wins.
//  Ports    : clk, rst      - clock, async active-high reset
//             req[1:0]      - request vector (bit 0 = A, bit 1 = B)
//             advance       - a grant was consumed this cycle; remember it
//             gnt[1:0]      - one-hot grant (zero when no request)
//             gnt_id        - id of the current winner
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
   import dff_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic last;

   always_comb begin
      gnt_id = ID_A;
      if (req == 2'b10) begin
         gnt_id = ID_B;
      end else if (req == 2'b11) begin
         gnt_id = (last == ID_A) ? ID_B : ID_A;
      end
      gnt = 2'b00;
      if (req != 2'b00) begin
         gnt = (gnt_id == ID_B) ? 2'b10 : 2'b01;
      end
   end

   // Reset to B so that A takes the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= ID_B;
      end else if (advance && (req != 2'b00)) begin
         last <= gnt_id;
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dff_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_mem_arbiter
//  Purpose  : Two-port round-robin sequencer in front of the 16x8 DFF RAM.
//             Serialises A/B read/write commands onto the RAM strobes and
//             returns a one-cycle done pulse per requester plus read data.
//  Ports    : clk, rst                       - clock, async active-high reset
//             a_valid/a_ready/a_we/a_addr/a_wdata/a_done - requester A
//             b_valid/b_ready/b_we/b_addr/b_wdata/b_done - requester B
//             rdata                          - read data, valid with done
//             mem_addr/mem_wdata/mem_rin/mem_rout_n/mem_rdata - RAM side
//             grant_cnt_a/grant_cnt_b        - saturating grant counters
//  Options  : DFF_MEM_ARB_STATS_EN enables the grant counters; when it is
//             undefined both counter outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module dff_mem_arbiter
   import dff_mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_done,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rin,
   output logic              mem_rout_n,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  grant_cnt_a,
   output logic [CNT_W-1:0]  grant_cnt_b
);

   arb_state_t        state, state_nxt;
   logic              cmd_we;
   logic              cmd_id;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              gnt_id;
   logic              idle;
   logic              accept;

   assign idle   = (state == IDLE);
   assign req    = {b_valid, a_valid};
   // The picker only grants a valid requester, so any request in IDLE is an
   // accept of the winner.
   assign accept = idle && (req != 2'b00);

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (accept),
      .gnt     (gnt),
      .gnt_id  (gnt_id)
   );

   assign a_ready = idle && gnt[0];
   assign b_ready = idle && gnt[1];

   // The latched command drives the RAM bus directly; the strobes below
   // qualify it, so holding stale values outside ACCESS is harmless.
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      mem_rin    = 1'b0;
      mem_rout_n = 1'b1;
      a_done     = 1'b0;
      b_done     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (cmd_we) begin
               mem_rout_n = 1'b0;
               state_nxt  = DONE;
            end else begin
               mem_rin   = 1'b1;
               state_nxt = RDWAIT;
            end
         end
         RDWAIT: begin
            state_nxt = DONE;
         end
         DONE: begin
            a_done    = (cmd_id == ID_A);
            b_done    = (cmd_id == ID_B);
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_we    <= 1'b0;
         cmd_id    <= ID_A;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (accept) begin
         cmd_id    <= gnt_id;
         cmd_we    <= (gnt_id == ID_B) ? b_we    : a_we;
         cmd_addr  <= (gnt_id == ID_B) ? b_addr  : a_addr;
         cmd_wdata <= (gnt_id == ID_B) ? b_wdata : a_wdata;
      end
   end

   // RAM output is registered inside the RAM, so it is valid during RDWAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (state == RDWAIT) begin
         rdata <= mem_rdata;
      end
   end

`ifdef DFF_MEM_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (accept) begin
         if ((gnt_id == ID_A) && (cnt_a != CNT_MAX)) begin
            cnt_a <= cnt_a + 1'b1;
         end
         if ((gnt_id == ID_B) && (cnt_b != CNT_MAX)) begin
            cnt_b <= cnt_b + 1'b1;
         end
      end
   end

   assign grant_cnt_a = cnt_a;
   assign grant_cnt_b = cnt_b;
`else
   assign grant_cnt_a = '0;
   assign grant_cnt_b = '0;
`endif

endmodule : dff_mem_arbiter
`default_nettype wire

// File: tb/tb_dff_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_mem_arbiter
//  Purpose  : Self-checking bench for dff_mem_arbiter with a behavioural RAM.
//             Directed vector table, hand-written corner sequences, and a
//             randomized run against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dff_mem_arbiter;
   import dff_mem_arb_pkg::*;

`ifdef DFF_MEM_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
   logic [3:0] a_addr = '0, b_addr = '0;
   logic [7:0] a_wdata = '0, b_wdata = '0;
   logic       a_ready, a_done, b_ready, b_done;
   logic [7:0] rdata, mem_wdata, mem_rdata;
   logic [3:0] mem_addr;
   logic       mem_rin, mem_rout_n;
   logic [7:0] grant_cnt_a, grant_cnt_b;

   always #5 clk = ~clk;

   dff_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_done(a_done),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_done(b_done),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rin(mem_rin), .mem_rout_n(mem_rout_n), .mem_rdata(mem_rdata),
      .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
   );

   // Behavioural 16x8 RAM with registered read port.
   logic [7:0] ram [16];
   always @(posedge clk) begin
      if (!mem_rout_n) ram[mem_addr] <= mem_wdata;
      if (mem_rin)     mem_rdata     <= ram[mem_addr];
   end

   logic [7:0] ref_mem   [16];
   bit         ref_known [16];
   int total = 0;
   int bad   = 0;

   typedef struct {
      bit       use_b;
      bit       we;
      logic [3:0] addr;
      logic [7:0] wdata;
      int       lat;
      logic [7:0] rd;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit use_b, input bit v, input bit we,
                        input logic [3:0] ad, input logic [7:0] wd);
      if (use_b) begin
         b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
      end else begin
         a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
      end
   endtask

   // Returns at the negedge where the signal is seen (ok=1), otherwise just
   // after a posedge once the bound expires (ok=0).
   task automatic wait_sig(input int which, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         case (which)
            0:       ok = a_ready;
            1:       ok = b_ready;
            2:       ok = a_ready | b_ready;
            3:       ok = a_done;
            default: ok = b_done;
         endcase
         if (ok) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, " a_ready"}, 8'(a_ready), 8'd0);
      chk({nm, " b_ready"}, 8'(b_ready), 8'd0);
      chk({nm, " a_done"}, 8'(a_done), 8'd0);
      chk({nm, " b_done"}, 8'(b_done), 8'd0);
      chk({nm, " rdata"}, rdata, 8'h00);
      chk({nm, " mem_addr"}, 8'(mem_addr), 8'h00);
      chk({nm, " mem_wdata"}, mem_wdata, 8'h00);
      chk({nm, " mem_rin"}, 8'(mem_rin), 8'd0);
      chk({nm, " mem_rout_n"}, 8'(mem_rout_n), 8'd1);
      chk({nm, " grant_cnt_a"}, grant_cnt_a, 8'd0);
      chk({nm, " grant_cnt_b"}, grant_cnt_b, 8'd0);
   endtask

   // One isolated command: acceptance, RAM strobe at T+1, done latency, rdata.
   task automatic do_single(input bit use_b, input bit we, input logic [3:0] ad,
                            input logic [7:0] wd, input int lat_exp,
                            input logic [7:0] rd_exp, input string nm);
      bit ok;
      bit seen;
      int lat;
      drive(use_b, 1'b1, we, ad, wd);
      wait_sig(use_b ? 1 : 0, 10, ok);
      chk({nm, " accepted"}, 8'(ok), 8'd1);
      if (!ok) begin
         drive(use_b, 1'b0, we, ad, wd);
         return;
      end
      chk({nm, " other ready"}, 8'(use_b ? a_ready : b_ready), 8'd0);
      step();
      drive(use_b, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom));
      @(negedge clk);
      chk({nm, " rout_n"}, 8'(mem_rout_n), 8'(!we));
      chk({nm, " rin"}, 8'(mem_rin), 8'(!we));
      chk({nm, " mem_addr"}, 8'(mem_addr), 8'(ad));
      if (we) chk({nm, " mem_wdata"}, mem_wdata, wd);
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 6) begin
         step();
         @(negedge clk);
         lat++;
         seen = use_b ? b_done : a_done;
      end
      chk({nm, " latency"}, 8'(lat), 8'(lat_exp));
      chk({nm, " other done"}, 8'(use_b ? a_done : b_done), 8'd0);
      chk({nm, " rdata"}, rdata, rd_exp);
      if (we) begin
         ref_mem[ad]   = wd;
         ref_known[ad] = 1'b1;
      end
      step();
      @(negedge clk);
      chk({nm, " done one cycle"}, 8'(use_b ? b_done : a_done), 8'd0);
      step();
   endtask

   // Randomized traffic checked against a transaction-level model: one
   // command in flight at a time, write done at accept+2, read at accept+3,
   // strobes at accept+1, ties go to whoever was not granted last.
   task automatic run_random(input int ncyc);
      bit         has [2];
      bit         rwe [2];
      logic [3:0] rad [2];
      logic [7:0] rwd [2];
      bit         busy, p_id, p_we, p_known, last, held_known, win, idle, any, dn;
      logic [3:0] p_ad;
      logic [7:0] p_wd, p_rd, held;
      int         acc, k;
      bit         gen;
      has[0] = 0; has[1] = 0; rwe[0] = 0; rwe[1] = 0;
      rad[0] = '0; rad[1] = '0; rwd[0] = '0; rwd[1] = '0;
      busy = 0; acc = 0; p_id = 0; p_we = 0; p_ad = '0; p_wd = '0; p_rd = '0;
      p_known = 0;
      last = ID_A;          // last grant before this phase was requester A
      held = 8'h00; held_known = 1'b1;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         gen = (cyc < ncyc - 10);
         for (int r = 0; r < 2; r++) begin
            if (has[r]) begin
               if ($urandom_range(0, 15) == 0) has[r] = 1'b0;
            end else if (gen && $urandom_range(0, 2) == 0) begin
               has[r] = 1'b1;
               rwe[r] = 1'($urandom);
               rad[r] = 4'($urandom);
               rwd[r] = 8'($urandom);
            end
            drive(r[0], has[r], rwe[r], rad[r], rwd[r]);
         end
         @(negedge clk);
         idle = !busy;
         any  = has[0] | has[1];
         if (has[0] && !has[1])      win = ID_A;
         else if (!has[0] && has[1]) win = ID_B;
         else                        win = (last == ID_A) ? ID_B : ID_A;
         chk("rnd a_ready", 8'(a_ready), 8'(idle && any && win == ID_A));
         chk("rnd b_ready", 8'(b_ready), 8'(idle && any && win == ID_B));
         k = cyc - acc;
         chk("rnd rin", 8'(mem_rin), 8'(busy && k == 1 && !p_we));
         chk("rnd rout_n", 8'(mem_rout_n), 8'(!(busy && k == 1 && p_we)));
         if (busy && k == 1) begin
            chk("rnd mem_addr", 8'(mem_addr), 8'(p_ad));
            if (p_we) chk("rnd mem_wdata", mem_wdata, p_wd);
         end
         dn = busy && (k == (p_we ? 2 : 3));
         chk("rnd a_done", 8'(a_done), 8'(dn && p_id == ID_A));
         chk("rnd b_done", 8'(b_done), 8'(dn && p_id == ID_B));
         if (dn && !p_we) begin
            held       = p_rd;
            held_known = p_known;
         end
         if (held_known) chk("rnd rdata", rdata, held);
         if (dn) busy = 1'b0;
         if (idle && any) begin
            busy = 1'b1;
            acc  = cyc;
            p_id = win;
            p_we = rwe[win];
            p_ad = rad[win];
            p_wd = rwd[win];
            if (p_we) begin
               ref_mem[p_ad]   = p_wd;
               ref_known[p_ad] = 1'b1;
            end else begin
               p_rd    = ref_mem[p_ad];
               p_known = ref_known[p_ad];
            end
            last     = win;
            has[win] = 1'b0;
         end
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
   endtask

   initial begin
      bit ok;
      bit acc;
      int n;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i]   = 8'h00;
         ref_known[i] = 1'b0;
      end
      tbl[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 2, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 4'h3, 8'h00, 3, 8'hA5};
      tbl[2] = '{1'b1, 1'b1, 4'h7, 8'h3C, 2, 8'hA5};
      tbl[3] = '{1'b0, 1'b0, 4'h7, 8'h00, 3, 8'h3C};
      tbl[4] = '{1'b0, 1'b1, 4'hF, 8'hFF, 2, 8'h3C};
      tbl[5] = '{1'b0, 1'b1, 4'h0, 8'h01, 2, 8'h3C};
      tbl[6] = '{1'b1, 1'b0, 4'hF, 8'h00, 3, 8'hFF};
      tbl[7] = '{1'b0, 1'b0, 4'h0, 8'h00, 3, 8'h01};
      tbl[8] = '{1'b1, 1'b0, 4'h3, 8'h00, 3, 8'hA5};

      // Reset values
      #1 rst = 1'b1;
      #1 check_reset_vals("reset");
      step();
      step();
      rst = 1'b0;
      step();

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         do_single(tbl[i].use_b, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                   tbl[i].lat, tbl[i].rd, $sformatf("vec%0d", i));
      end

      // Two simultaneous readers alternate A, B, A, B
      do_single(1'b0, 1'b1, 4'h1, 8'h11, 2, 8'hA5, "prep a");
      do_single(1'b1, 1'b1, 4'h2, 8'h22, 2, 8'hA5, "prep b");
      drive(1'b0, 1'b1, 1'b0, 4'h1, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
      for (int g = 0; g < 4; g++) begin
         wait_sig(2, 8, ok);
         chk($sformatf("alt%0d accept", g), 8'(ok), 8'd1);
         if (!ok) break;
         chk($sformatf("alt%0d order", g), 8'({b_ready, a_ready}),
             (g % 2 == 0) ? 8'd1 : 8'd2);
         step();
         if (g == 3) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
         end
         wait_sig((g % 2 == 0) ? 3 : 4, 6, ok);
         chk($sformatf("alt%0d done", g), 8'(ok), 8'd1);
         chk($sformatf("alt%0d rdata", g), rdata, (g % 2 == 0) ? 8'h11 : 8'h22);
         if (ok) step();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;

      // B arrives while A is in ACCESS
      drive(1'b0, 1'b1, 1'b1, 4'h5, 8'h55);
      wait_sig(0, 8, ok);
      chk("late b: a accepted", 8'(ok), 8'd1);
      step();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 4'h5, 8'h00);
      @(negedge clk);
      chk("late b: ready in ACCESS", 8'(b_ready), 8'd0);
      step();
      @(negedge clk);
      chk("late b: a_done", 8'(a_done), 8'd1);
      chk("late b: ready in DONE", 8'(b_ready), 8'd0);
      step();
      @(negedge clk);
      chk("late b: ready after done", 8'(b_ready), 8'd1);
      step();
      b_valid = 1'b0;
      ref_mem[5] = 8'h55;
      ref_known[5] = 1'b1;
      wait_sig(4, 6, ok);
      chk("late b: b_done", 8'(ok), 8'd1);
      chk("late b: rdata", rdata, 8'h55);
      if (ok) step();

      // Reset during RDWAIT abandons the read
      drive(1'b0, 1'b1, 1'b0, 4'h5, 8'h00);
      wait_sig(0, 8, ok);
      chk("rst mid: accepted", 8'(ok), 8'd1);
      step();
      a_valid = 1'b0;
      @(negedge clk);
      chk("rst mid: rin", 8'(mem_rin), 8'd1);
      step();
      rst = 1'b1;
      #1 check_reset_vals("rst mid");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst mid: no a_done", 8'(a_done), 8'd0);
         step();
         if (i == 1) rst = 1'b0;
      end
      drive(1'b0, 1'b1, 1'b1, 4'h9, 8'h99);
      drive(1'b1, 1'b1, 1'b1, 4'hE, 8'hEE);
      #1;
      chk("rst mid: tie a_ready", 8'(a_ready), 8'd1);
      chk("rst mid: tie b_ready", 8'(b_ready), 8'd0);
      step();
      a_valid = 1'b0;
      b_valid = 1'b0;
      ref_mem[9] = 8'h99;
      ref_known[9] = 1'b1;
      wait_sig(3, 6, ok);
      chk("rst mid: tie a_done", 8'(ok), 8'd1);
      if (ok) step();

      // Randomized traffic
      run_random(700);

      // Grant counters
      rst = 1'b1;
      #1;
      chk("stats clr a", grant_cnt_a, 8'd0);
      chk("stats clr b", grant_cnt_b, 8'd0);
      step();
      rst = 1'b0;
      n = 0;
      drive(1'b0, 1'b1, 1'b1, 4'($urandom), 8'($urandom));
      for (int i = 0; i < 1500 && n < 300; i++) begin
         @(negedge clk);
         acc = a_ready;
         if (acc && n == 10) chk("stats mid a", grant_cnt_a, STATS ? 8'd10 : 8'd0);
         step();
         if (acc) begin
            n++;
            if (n == 300) a_valid = 1'b0;
            else drive(1'b0, 1'b1, 1'b1, 4'($urandom), 8'($urandom));
         end
      end
      chk("stats accepts", 8'(n == 300), 8'd1);
      repeat (4) step();
      chk("stats sat a", grant_cnt_a, STATS ? 8'd255 : 8'd0);
      chk("stats b", grant_cnt_b, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dff_mem_arbiter
`default_nettype wire
